// File: rtl/node_request_injector.sv
// node_request_injector: core-side network interface that queues local read/write requests,
// issues them as single-cycle flits to a mesh Node and returns read replies to the requester.
module node_request_injector #(
    parameter int NET_AW  = 4,
    parameter int BANK_AW = 8,
    parameter int DW      = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NET_AW-1:0]       localRouterAddress,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [NET_AW+BANK_AW-1:0] req_addr,
    input  logic [DW-1:0]           req_data,
    output logic                    resp_valid,
    output logic [DW-1:0]           resp_data,
    output logic                    resp_error,
    output logic [NET_AW+BANK_AW-1:0] destinationAddressOut,
    output logic [NET_AW-1:0]       requesterAddressOut,
    output logic                    readOut,
    output logic                    writeOut,
    output logic [DW-1:0]           dataOut,
    input  logic [NET_AW+BANK_AW-1:0] destinationAddressIn,
    input  logic [NET_AW-1:0]       requesterAddressIn,
    input  logic                    readIn,
    input  logic                    writeIn,
    input  logic [DW-1:0]           dataIn,
    output logic [7:0]              late_resp_count
);
    localparam int AW = NET_AW + BANK_AW;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT);
    localparam int EW = 1 + AW + DW;

    typedef enum logic [1:0] {IDLE, SENDW, SENDR, WAIT} stateT;

    stateT             state, nextState;
    logic [EW-1:0]     mem [DEPTH];
    logic [PW-1:0]     wrPtr, rdPtr;
    logic [PW:0]       count;
    logic [CW-1:0]     timer;
    logic              push, pop, match, timeout, inWait;
    logic              headWrite;
    logic [AW-1:0]     headAddr;
    logic [DW-1:0]     headData;
    logic              unusedIn;

    assign unusedIn = ^{destinationAddressIn, readIn};
    assign req_ready = count != (PW+1)'(DEPTH);
    assign push = req_valid & req_ready;
    assign {headWrite, headAddr, headData} = mem[rdPtr];
    assign match = writeIn && requesterAddressIn == localRouterAddress;
    assign inWait = state == WAIT;
    // Timer reaches TIMEOUT-1 on this edge; a coincident match still wins.
    assign timeout = timer == CW'(TIMEOUT - 2);

    always_comb begin
        nextState = state;
        pop = 1'b0;
        case (state)
            IDLE: begin
                pop = count != '0;
                nextState = !pop ? IDLE : headWrite ? SENDW : SENDR;
            end
            SENDW: nextState = IDLE;
            SENDR: nextState = WAIT;
            WAIT: nextState = (match || timeout) ? IDLE : WAIT;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        if (push) mem[wrPtr] <= {req_write, req_addr, req_data};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            timer <= '0;
            destinationAddressOut <= '0;
            requesterAddressOut <= '0;
            readOut <= 1'b0;
            writeOut <= 1'b0;
            dataOut <= '0;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_data <= '0;
            late_resp_count <= '0;
        end else begin
            state <= nextState;
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop) rdPtr <= rdPtr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
            timer <= inWait ? timer + 1'b1 : '0;
            destinationAddressOut <= pop ? headAddr : '0;
            requesterAddressOut <= pop ? localRouterAddress : '0;
            writeOut <= pop & headWrite;
            readOut <= pop & ~headWrite;
            dataOut <= (pop & headWrite) ? headData : '0;
            resp_valid <= inWait && (match || timeout);
            resp_error <= inWait && !match && timeout;
            resp_data <= (inWait && match) ? dataIn : '0;
            if (match && !inWait && late_resp_count != 8'hFF)
                late_resp_count <= late_resp_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_node_request_injector.sv
// tb_node_request_injector: vector table, directed corner sequences and random traffic
// against an edge-arithmetic reference model of the injector.
module tb_node_request_injector;
    localparam int DEPTH = 4;
    localparam int TIMEOUT = 64;

    logic        clk, reset;
    logic [3:0]  localRouterAddress;
    logic        req_valid, req_ready, req_write;
    logic [11:0] req_addr;
    logic [31:0] req_data;
    logic        resp_valid, resp_error;
    logic [31:0] resp_data;
    logic [11:0] destinationAddressOut, destinationAddressIn;
    logic [3:0]  requesterAddressOut, requesterAddressIn;
    logic        readOut, writeOut, readIn, writeIn;
    logic [31:0] dataOut, dataIn;
    logic [7:0]  late_resp_count;

    node_request_injector #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .localRouterAddress(localRouterAddress),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_data(req_data),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_error(resp_error),
        .destinationAddressOut(destinationAddressOut), .requesterAddressOut(requesterAddressOut),
        .readOut(readOut), .writeOut(writeOut), .dataOut(dataOut),
        .destinationAddressIn(destinationAddressIn), .requesterAddressIn(requesterAddressIn),
        .readIn(readIn), .writeIn(writeIn), .dataIn(dataIn),
        .late_resp_count(late_resp_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: requests are a queue; issue timing is tracked as edge numbers.
    typedef struct {logic w; logic [11:0] a; logic [31:0] d;} reqT;
    reqT q[$];
    int e, readAt, freeAt;
    logic        mWrite, mRead, mRespV, mRespE, mReady;
    logic [11:0] mDest;
    logic [3:0]  mReq;
    logic [31:0] mData, mRespD;
    logic [7:0]  mLate;

    task automatic modelReset();
        q.delete();
        e = 0; readAt = -1; freeAt = 0;
        {mWrite, mRead, mRespV, mRespE, mDest, mReq, mData, mRespD, mLate} = '0;
        mReady = 1'b1;
    endtask

    task automatic modelEdge();
        int preSize;
        logic m;
        reqT h;
        if (!reset) begin
            modelReset();
            return;
        end
        preSize = q.size();
        m = writeIn && requesterAddressIn == localRouterAddress;
        {mWrite, mRead, mRespV, mRespE, mDest, mReq, mData, mRespD} = '0;
        if (readAt >= 0 && e >= readAt + 2) begin
            if (m) begin
                mRespV = 1'b1; mRespD = dataIn;
            end else if (e == readAt + TIMEOUT) begin
                mRespV = 1'b1; mRespE = 1'b1;
            end
            if (mRespV) begin
                readAt = -1; freeAt = e + 1;
            end
        end else if (m && mLate != 8'hFF) mLate++;
        if (e >= freeAt && q.size() > 0) begin
            h = q.pop_front();
            mWrite = h.w; mRead = !h.w; mDest = h.a; mReq = localRouterAddress;
            mData = h.w ? h.d : 32'h0;
            if (h.w) freeAt = e + 2;
            else begin
                readAt = e; freeAt = 1 << 30;
            end
        end
        if (req_valid && preSize < DEPTH) q.push_back('{req_write, req_addr, req_data});
        mReady = q.size() < DEPTH;
        e++;
    endtask

    task automatic checkModel();
        chk("model", 128'({writeOut, readOut, destinationAddressOut, requesterAddressOut, dataOut,
                           resp_valid, resp_error, resp_data, req_ready, late_resp_count}),
                     128'({mWrite, mRead, mDest, mReq, mData, mRespV, mRespE, mRespD, mReady, mLate}));
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
        checkModel();
    endtask

    task automatic idleInputs();
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0;
        writeIn = 1'b0; requesterAddressIn = '0; dataIn = '0;
    endtask

    task automatic pushOne(input logic w, input logic [11:0] a, input logic [31:0] d);
        req_valid = 1'b1; req_write = w; req_addr = a; req_data = d;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic waitReadOut();
        int n = 0;
        while (!readOut && n < 100) begin
            tick();
            n++;
        end
        chk("readOut seen", 128'(readOut), 128'(1'b1));
    endtask

    task automatic reply(input logic [31:0] d);
        writeIn = 1'b1; requesterAddressIn = 4'h5; dataIn = d;
        tick();
        writeIn = 1'b0; requesterAddressIn = '0; dataIn = '0;
    endtask

    typedef struct {
        logic rv, rw; logic [11:0] ra; logic [31:0] rd;
        logic wi; logic [3:0] rai; logic [31:0] di;
        logic ewo, ero; logic [11:0] edao; logic [3:0] erao; logic [31:0] edo;
        logic ersv; logic [31:0] ersd; logic erse, erdy;
    } vecT;
    vecT vecs[10];

    initial begin
        logic [31:0] wd[5];
        int n, k, lastT, t;
        logic [7:0] lateBefore;
        logic acc;
        for (int i = 0; i < 10; i++) begin
            vecs[i] = '{default: '0};
            vecs[i].erdy = 1'b1;
        end
        vecs[0].rv = 1'b1; vecs[0].rw = 1'b1; vecs[0].ra = 12'h3A7; vecs[0].rd = 32'hDEADBEEF;
        vecs[1].ewo = 1'b1; vecs[1].edao = 12'h3A7; vecs[1].erao = 4'h5; vecs[1].edo = 32'hDEADBEEF;
        vecs[2].rv = 1'b1; vecs[2].ra = 12'h210;
        vecs[3].ero = 1'b1; vecs[3].edao = 12'h210; vecs[3].erao = 4'h5;
        vecs[8].wi = 1'b1; vecs[8].rai = 4'h5; vecs[8].di = 32'h12345678;
        vecs[8].ersv = 1'b1; vecs[8].ersd = 32'h12345678;

        reset = 1'b0; localRouterAddress = 4'h5; readIn = 1'b0; destinationAddressIn = '0;
        idleInputs();
        modelReset();
        tick();
        tick();
        chk("reset state", 128'({writeOut, readOut, destinationAddressOut, requesterAddressOut, dataOut,
                                 resp_valid, resp_error, resp_data, req_ready, late_resp_count}),
                           128'({1'b0, 1'b0, 12'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 8'h0}));
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            req_valid = vecs[i].rv; req_write = vecs[i].rw; req_addr = vecs[i].ra; req_data = vecs[i].rd;
            writeIn = vecs[i].wi; requesterAddressIn = vecs[i].rai; dataIn = vecs[i].di;
            tick();
            chk($sformatf("vec[%0d]", i),
                128'({writeOut, readOut, destinationAddressOut, requesterAddressOut, dataOut,
                      resp_valid, resp_data, resp_error, req_ready}),
                128'({vecs[i].ewo, vecs[i].ero, vecs[i].edao, vecs[i].erao, vecs[i].edo,
                      vecs[i].ersv, vecs[i].ersd, vecs[i].erse, vecs[i].erdy}));
        end
        idleInputs();

        // Timeout after TIMEOUT cycles, then a late reply.
        pushOne(1'b0, 12'h111, 32'h0);
        waitReadOut();
        n = 0;
        while (!resp_valid && n < 200) begin
            tick();
            n++;
        end
        chk("timeout latency", 128'(n), 128'(TIMEOUT));
        chk("timeout resp", 128'({resp_valid, resp_error, resp_data}), 128'({1'b1, 1'b1, 32'h0}));
        lateBefore = late_resp_count;
        repeat (5) tick();
        reply(32'hCAFE0001);
        chk("late reply count", 128'(late_resp_count), 128'(lateBefore + 8'd1));
        chk("late reply no resp", 128'(resp_valid), 128'(1'b0));
        repeat (2) tick();

        // FIFO fills while a read is outstanding, drains in order afterwards.
        pushOne(1'b0, 12'h222, 32'h0);
        waitReadOut();
        for (int i = 0; i < 5; i++) wd[i] = 32'hA0000000 + 32'(i);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ready before push %0d", i), 128'(req_ready), 128'(1'b1));
            pushOne(1'b1, 12'h300 + 12'(i), wd[i]);
        end
        chk("full ready", 128'(req_ready), 128'(1'b0));
        req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h304; req_data = wd[4];
        repeat (3) tick();
        chk("full held", 128'(req_ready), 128'(1'b0));
        writeIn = 1'b1; requesterAddressIn = 4'h5; dataIn = 32'h0BADF00D;
        tick();
        writeIn = 1'b0; requesterAddressIn = '0; dataIn = '0;
        chk("fill reply", 128'({resp_valid, resp_data}), 128'({1'b1, 32'h0BADF00D}));
        k = 0; lastT = 0;
        for (t = 0; t < 20; t++) begin
            acc = req_valid && req_ready;
            tick();
            if (acc) req_valid = 1'b0;
            if (writeOut) begin
                if (k < 5) chk($sformatf("order %0d", k), 128'(dataOut), 128'(wd[k]));
                if (k > 0) chk($sformatf("spacing %0d", k), 128'(t - lastT), 128'(2));
                lastT = t;
                k++;
            end
        end
        chk("drained flits", 128'(k), 128'(5));
        idleInputs();

        // Asynchronous reset mid-WAIT with queued requests.
        pushOne(1'b0, 12'h0AB, 32'h0);
        waitReadOut();
        for (int i = 0; i < 3; i++) pushOne(1'b1, 12'h0C0 + 12'(i), 32'h55 + 32'(i));
        tick();
        #2 reset = 1'b0;
        modelReset();
        #1;
        chk("async reset", 128'({writeOut, readOut, destinationAddressOut, requesterAddressOut, dataOut,
                                 resp_valid, req_ready, late_resp_count}),
                           128'({1'b0, 1'b0, 12'h0, 4'h0, 32'h0, 1'b0, 1'b1, 8'h0}));
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reply(32'h77777777);
        chk("abandoned reply late", 128'({late_resp_count, resp_valid}), 128'({8'd1, 1'b0}));
        n = 0;
        repeat (6) begin
            tick();
            if (writeOut || readOut) n++;
        end
        chk("fifo emptied", 128'(n), 128'(0));

        // Reply on the very edge the timer reaches TIMEOUT-1.
        pushOne(1'b0, 12'h444, 32'h0);
        waitReadOut();
        repeat (TIMEOUT - 1) tick();
        reply(32'hFEEDFACE);
        chk("edge reply", 128'({resp_valid, resp_error, resp_data}), 128'({1'b1, 1'b0, 32'hFEEDFACE}));
        tick();
        chk("edge reply single pulse", 128'(resp_valid), 128'(1'b0));

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            req_valid = $urandom_range(0, 2) == 0;
            req_write = 1'($urandom_range(0, 1));
            req_addr = 12'($urandom);
            req_data = $urandom;
            writeIn = $urandom_range(0, 11) == 0;
            requesterAddressIn = ($urandom_range(0, 1) == 0) ? 4'h5 : 4'($urandom);
            dataIn = $urandom;
            readIn = 1'($urandom_range(0, 1));
            destinationAddressIn = 12'($urandom);
            tick();
        end
        idleInputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
